// File: rtl/cnet_prog_ctrl.sv
// SelectMAP initiator for CNET reprogramming: pulses PROG_B, waits for INIT_B,
// then streams 32-bit words as bit-reversed bytes under a generated CCLK.
module cnet_prog_ctrl #(
  parameter int CCLK_DIV      = 2,
  parameter int PROG_B_CYCLES = 16,
  parameter int INIT_TIMEOUT  = 1024,
  parameter int DONE_TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  input  logic        word_last,
  output logic        word_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        rp_prog_b,
  input  logic        rp_init_b,
  output logic        rp_cs_b,
  output logic        rp_rdwr_b,
  output logic [7:0]  rp_data,
  input  logic        rp_done,
  output logic        rp_cclk
);

  localparam int TMO_MAX = (INIT_TIMEOUT > DONE_TIMEOUT) ? INIT_TIMEOUT : DONE_TIMEOUT;
  localparam int CNT_MAX = (TMO_MAX > PROG_B_CYCLES) ? TMO_MAX : PROG_B_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(CCLK_DIV + 1);

  localparam logic [1:0] ERR_INIT = 2'b01;
  localparam logic [1:0] ERR_CRC  = 2'b10;
  localparam logic [1:0] ERR_DONE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_PROG_B, S_GUARD, S_WAIT_INIT, S_LOAD, S_SEND, S_WAIT_DONE, S_ERROR
  } state_e;

  state_e             state_q;
  logic [DIV_W-1:0]   div_q;
  logic               cclk_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         bcnt_q;
  logic [31:0]        wbuf_q;
  logic               wlast_q;
  logic               held_q;
  logic [23:0]        sr_q;
  logic               slast_q;
  logic               prog_b_q;
  logic               cs_b_q;
  logic [7:0]         data_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;
  logic [1:0]         err_q;
  logic               init_s1_q, init_s2_q;
  logic               done_s1_q, done_s2_q;

  logic               tick, rise, fall, hs;
  logic               err_hit_d;
  logic [1:0]         err_code_d;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign tick = busy_q && (div_q == DIV_W'(CCLK_DIV - 1));
  assign rise = tick && !cclk_q;
  assign fall = tick && cclk_q;

  // Prefetch during the last byte of a non-final word keeps cs_b low between words.
  assign word_ready = !held_q &&
                      ((state_q == S_LOAD) || (state_q == S_SEND && bcnt_q == 2'd3 && !slast_q));
  assign hs = word_valid && word_ready;

  always_comb begin
    err_hit_d  = 1'b0;
    err_code_d = 2'b00;
    if (!init_s2_q && (state_q == S_LOAD || state_q == S_SEND)) begin
      err_hit_d  = 1'b1;
      err_code_d = ERR_CRC;
    end else if (state_q == S_WAIT_INIT && cnt_q == CNT_W'(INIT_TIMEOUT)) begin
      err_hit_d  = 1'b1;
      err_code_d = ERR_INIT;
    end else if (state_q == S_WAIT_DONE && cnt_q == CNT_W'(DONE_TIMEOUT)) begin
      err_hit_d  = 1'b1;
      err_code_d = ERR_DONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cclk_q    <= 1'b0;
      cnt_q     <= '0;
      bcnt_q    <= 2'd0;
      wbuf_q    <= '0;
      wlast_q   <= 1'b0;
      held_q    <= 1'b0;
      sr_q      <= '0;
      slast_q   <= 1'b0;
      prog_b_q  <= 1'b1;
      cs_b_q    <= 1'b1;
      data_q    <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_q     <= 2'b00;
      init_s1_q <= 1'b0;
      init_s2_q <= 1'b0;
      done_s1_q <= 1'b0;
      done_s2_q <= 1'b0;
    end else begin
      init_s1_q <= rp_init_b;
      init_s2_q <= init_s1_q;
      done_s1_q <= rp_done;
      done_s2_q <= done_s1_q;

      if (hs) begin
        wbuf_q  <= word_data;
        wlast_q <= word_last;
        held_q  <= 1'b1;
      end

      if (tick) begin
        div_q  <= '0;
        cclk_q <= !cclk_q;
      end else if (busy_q) begin
        div_q <= div_q + DIV_W'(1);
      end

      if (err_hit_d) begin
        state_q  <= S_ERROR;
        busy_q   <= 1'b0;
        error_q  <= 1'b1;
        err_q    <= err_code_d;
        prog_b_q <= 1'b1;
        cs_b_q   <= 1'b1;
        cclk_q   <= 1'b0;
        div_q    <= '0;
        held_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_ERROR: begin
            if (start) begin
              state_q  <= S_PROG_B;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              error_q  <= 1'b0;
              err_q    <= 2'b00;
              prog_b_q <= 1'b0;
              cnt_q    <= '0;
              div_q    <= '0;
              cclk_q   <= 1'b0;
              held_q   <= 1'b0;
            end
          end
          S_PROG_B: begin
            if (rise && cnt_q != CNT_W'(PROG_B_CYCLES)) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else if (fall && cnt_q == CNT_W'(PROG_B_CYCLES)) begin
              prog_b_q <= 1'b1;
              cnt_q    <= '0;
              state_q  <= S_GUARD;
            end
          end
          S_GUARD: begin
            if (rise) begin
              if (cnt_q == CNT_W'(1)) begin
                cnt_q   <= '0;
                state_q <= S_WAIT_INIT;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          S_WAIT_INIT: begin
            if (init_s2_q) begin
              cnt_q   <= '0;
              state_q <= S_LOAD;
            end else if (rise) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_LOAD: begin
            if (fall) begin
              if (held_q) begin
                data_q  <= rev8(wbuf_q[7:0]);
                sr_q    <= wbuf_q[31:8];
                slast_q <= wlast_q;
                held_q  <= 1'b0;
                bcnt_q  <= 2'd0;
                cs_b_q  <= 1'b0;
                state_q <= S_SEND;
              end else begin
                cs_b_q <= 1'b1;
              end
            end
          end
          S_SEND: begin
            if (rise && bcnt_q == 2'd3) begin
              cnt_q   <= '0;
              state_q <= slast_q ? S_WAIT_DONE : S_LOAD;
            end else if (fall) begin
              data_q <= rev8(sr_q[7:0]);
              sr_q   <= {8'h00, sr_q[23:8]};
              bcnt_q <= bcnt_q + 2'd1;
            end
          end
          S_WAIT_DONE: begin
            if (done_s2_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cs_b_q  <= 1'b1;
              cclk_q  <= 1'b0;
              div_q   <= '0;
            end else begin
              if (fall) cs_b_q <= 1'b1;
              if (rise) cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_q;
  assign rp_prog_b = prog_b_q;
  assign rp_cs_b   = cs_b_q;
  assign rp_rdwr_b = 1'b0;
  assign rp_data   = data_q;
  assign rp_cclk   = cclk_q;

endmodule

// File: tb/tb_cnet_prog_ctrl.sv
// Scoreboard bench for cnet_prog_ctrl with a behavioural CNET pin model.
module tb_cnet_prog_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_valid = 1'b0;
  logic        word_last = 1'b0;
  logic        word_ready, busy, done, error;
  logic [1:0]  err_code;
  logic        rp_prog_b, rp_cs_b, rp_rdwr_b, rp_cclk;
  logic [7:0]  rp_data;
  logic        rp_init_b = 1'b1;
  logic        rp_done = 1'b0;

  always #5 clk = ~clk;

  cnet_prog_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .word_data(word_data), .word_valid(word_valid), .word_last(word_last),
    .word_ready(word_ready), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .rp_prog_b(rp_prog_b), .rp_init_b(rp_init_b),
    .rp_cs_b(rp_cs_b), .rp_rdwr_b(rp_rdwr_b), .rp_data(rp_data),
    .rp_done(rp_done), .rp_cclk(rp_cclk)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_b [0:255];
  int          exp_wr, exp_rd;
  logic [31:0] words [0:7];

  int bytes_seen, prog_rises, prog_pulses, rises_total, rises_after_last, gaps;
  int exp_total, crc_at;
  bit init_stuck, done_en;
  logic cclk_prev, prog_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // CNET side: observes CCLK rises, checks bytes, drives INIT_B / DONE.
  task automatic monitor();
    int init_rel = 0;
    forever begin
      @(negedge clk);
      if (prog_prev && !rp_prog_b) begin
        prog_pulses++;
        prog_rises = 0; rises_total = 0; bytes_seen = 0;
        rises_after_last = 0; gaps = 0;
      end
      if (rp_cclk && !cclk_prev) begin
        rises_total++;
        rises_after_last++;
        if (!rp_prog_b) prog_rises++;
        if (!rp_cs_b) begin
          rises_after_last = 0;
          if (exp_rd < exp_wr) begin
            chk($sformatf("byte%0d", exp_rd), rp_data, exp_b[exp_rd]);
            exp_rd++;
          end else begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%02h with cs_b low, required no byte (words queued %0d)",
                     rp_data, exp_wr / 4);
          end
          bytes_seen++;
        end else if (bytes_seen > 0 && bytes_seen < exp_total) begin
          gaps++;
        end
      end
      cclk_prev = rp_cclk;
      prog_prev = rp_prog_b;

      if (!rp_prog_b) begin
        init_rel  = 0;
        rp_init_b = 1'b0;
        rp_done   = 1'b0;
      end else begin
        if (init_stuck || (crc_at > 0 && bytes_seen >= crc_at)) begin
          rp_init_b = 1'b0;
        end else if (!rp_init_b) begin
          init_rel++;
          if (init_rel >= 5) rp_init_b = 1'b1;
        end
        if (done_en && exp_total > 0 && bytes_seen >= exp_total) rp_done = 1'b1;
      end
    end
  endtask

  task automatic setup(input int total, input int crc, input bit stuck, input bit den);
    exp_wr = 0; exp_rd = 0;
    exp_total = total; crc_at = crc; init_stuck = stuck; done_en = den;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers words[0..n-1]; on each accepted word the expected pin bytes are queued.
  task automatic feed(input int n, input bit toggle, input int limit);
    int  i = 0;
    int  cyc = 0;
    bit  hs;
    logic [7:0] b;
    while (i < n && cyc < limit) begin
      word_data  = words[i];
      word_last  = (i == n - 1);
      word_valid = toggle ? (((cyc / 8) % 2) == 0) : 1'b1;
      @(negedge clk);
      hs = word_valid && word_ready;
      if (!busy) break;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        for (int k = 0; k < 4; k++) begin
          b = words[i][8*k +: 8];
          exp_b[exp_wr] = {<<{b}};
          exp_wr++;
        end
        i++;
      end
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int c = 0;
    while (busy && c < limit) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, "_finished"}, busy, 1'b0);
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) words[i] = $urandom;
  endtask

  initial begin
    int pp0;
    int c;
    cclk_prev = 1'b0;
    prog_prev = 1'b1;
    setup(0, 0, 0, 0);
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_prog_b", rp_prog_b, 1'b1);
    chk("rst_cs_b", rp_cs_b, 1'b1);
    chk("rst_rdwr_b", rp_rdwr_b, 1'b0);
    chk("rst_data", rp_data, 8'h00);
    chk("rst_cclk", rp_cclk, 1'b0);
    chk("rst_word_ready", word_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_err_code", err_code, 2'b00);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: two-word bitstream, back-to-back
    setup(8, 0, 0, 1);
    words[0] = 32'h04030201;
    words[1] = 32'h08070605;
    pulse_start();
    chk("s1_busy", busy, 1'b1);
    chk("s1_prog_low", rp_prog_b, 1'b0);
    feed(2, 1'b0, 4000);
    wait_idle("s1", 20000);
    chk("s1_done", done, 1'b1);
    chk("s1_error", error, 1'b0);
    chk("s1_prog_rises", prog_rises, 16);
    chk("s1_bytes", bytes_seen, 8);
    chk("s1_scoreboard_drained", exp_rd, exp_wr);
    chk("s1_cs_gaps", gaps, 0);
    chk("s1_cs_b_idle", rp_cs_b, 1'b1);

    // 2: INIT_B never releases
    setup(0, 0, 1, 0);
    pulse_start();
    wait_idle("s2", 20000);
    chk("s2_error", error, 1'b1);
    chk("s2_err_code", err_code, 2'b01);
    chk("s2_rises", rises_total, 16 + 2 + 1024);
    chk("s2_prog_b", rp_prog_b, 1'b1);
    chk("s2_cs_b", rp_cs_b, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("s2_cclk_stopped", rp_cclk, 1'b0);
    chk("s2_no_more_rises", rises_total, 16 + 2 + 1024);

    // 3: CRC error after the first word
    setup(12, 4, 0, 1);
    rand_words(3);
    pulse_start();
    chk("s3_err_cleared", error, 1'b0);
    feed(3, 1'b0, 4000);
    wait_idle("s3", 20000);
    chk("s3_error", error, 1'b1);
    chk("s3_err_code", err_code, 2'b10);
    chk("s3_cs_b", rp_cs_b, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("s3_bytes", bytes_seen, 4);

    // 4: gappy word supply
    setup(12, 0, 0, 1);
    rand_words(3);
    pulse_start();
    feed(3, 1'b1, 4000);
    wait_idle("s4", 20000);
    chk("s4_done", done, 1'b1);
    chk("s4_error", error, 1'b0);
    chk("s4_bytes", bytes_seen, 12);
    chk("s4_scoreboard_drained", exp_rd, 12);

    // 5: DONE never rises, then a clean retry
    setup(8, 0, 0, 0);
    rand_words(2);
    pulse_start();
    feed(2, 1'b0, 4000);
    wait_idle("s5", 30000);
    chk("s5_error", error, 1'b1);
    chk("s5_err_code", err_code, 2'b11);
    chk("s5_rises_after_last", rises_after_last, 4096);
    chk("s5_bytes", bytes_seen, 8);
    setup(8, 0, 0, 1);
    words[0] = 32'h04030201;
    words[1] = 32'h08070605;
    pulse_start();
    chk("s5r_error_cleared", error, 1'b0);
    chk("s5r_err_code_cleared", err_code, 2'b00);
    chk("s5r_busy", busy, 1'b1);
    feed(2, 1'b0, 4000);
    wait_idle("s5r", 20000);
    chk("s5r_done", done, 1'b1);
    chk("s5r_error", error, 1'b0);
    chk("s5r_bytes", bytes_seen, 8);
    chk("s5r_prog_rises", prog_rises, 16);

    // 6: async reset mid-SEND, then start while busy is ignored
    setup(8, 0, 0, 1);
    rand_words(2);
    pulse_start();
    fork
      feed(2, 1'b0, 4000);
    join_none
    c = 0;
    while (bytes_seen < 2 && c < 2000) begin
      @(posedge clk); #1;
      c++;
    end
    chk("s6_reached_send", bytes_seen >= 2, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("s6_rst_prog_b", rp_prog_b, 1'b1);
    chk("s6_rst_cs_b", rp_cs_b, 1'b1);
    chk("s6_rst_cclk", rp_cclk, 1'b0);
    chk("s6_rst_data", rp_data, 8'h00);
    chk("s6_rst_busy", busy, 1'b0);
    chk("s6_rst_word_ready", word_ready, 1'b0);
    @(posedge clk); #1;
    pulse_start();
    chk("s6_start_in_reset_busy", busy, 1'b0);
    chk("s6_start_in_reset_prog_b", rp_prog_b, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    setup(8, 0, 0, 1);
    rand_words(2);
    pulse_start();
    c = 0;
    while (!rp_prog_b && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    pp0 = prog_pulses;
    pulse_start();
    repeat (50) @(posedge clk);
    #1;
    chk("s6_no_repulse", prog_pulses, pp0);
    chk("s6_still_busy", busy, 1'b1);
    feed(2, 1'b0, 4000);
    wait_idle("s6", 20000);
    chk("s6_done", done, 1'b1);
    chk("s6_bytes", bytes_seen, 8);
    chk("s6_prog_rises", prog_rises, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
